// File: rtl/simon_seq_engine.sv
// Parametrised Simon game core: grows a random sequence one step per round,
// plays it back on LED/tone, checks the player's presses and reports score/lose/win.
module simon_seq_engine #(
    parameter int  NUM_CH        = 4,
    parameter int  MAX_LEN       = 32,
    parameter int  STEP_TICKS    = 25_000_000,
    parameter int  GAP_TICKS     = 12_500_000,
    parameter int  TIMEOUT_TICKS = 150_000_000,
    localparam int IW            = $clog2(NUM_CH),
    localparam int SW            = $clog2(MAX_LEN + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [NUM_CH-1:0] btn,
    input  logic [IW-1:0]     rand_idx,
    output logic [NUM_CH-1:0] led,
    output logic              tone_en,
    output logic [IW-1:0]     tone_sel,
    output logic [SW-1:0]     score,
    output logic              awaiting_input,
    output logic              lose,
    output logic              win
);

    // state      | meaning
    // S_IDLE     | waiting for the first start
    // S_CLEAR    | reset len and score for a new game
    // S_APPEND   | store one random step, restart playback at step 0
    // S_PLAY_ON  | step idx lit with its tone for STEP_TICKS cycles
    // S_PLAY_GAP | dark for GAP_TICKS cycles between steps
    // S_WAIT_IN  | player repeats the sequence, timeout running
    // S_LOSE     | wrong press or timeout, score frozen
    // S_WIN      | MAX_LEN rounds completed, score frozen
    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_APPEND,
        S_PLAY_ON,
        S_PLAY_GAP,
        S_WAIT_IN,
        S_LOSE,
        S_WIN
    } state_t;

    localparam int MAX_SG    = (STEP_TICKS > GAP_TICKS) ? STEP_TICKS : GAP_TICKS;
    localparam int MAX_TICKS = (MAX_SG > TIMEOUT_TICKS) ? MAX_SG : TIMEOUT_TICKS;
    localparam int TW        = $clog2(MAX_TICKS + 1);
    localparam int AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    state_t            state;
    state_t            state_d;
    logic [SW-1:0]     len;
    logic [SW-1:0]     len_d;
    logic [SW-1:0]     idx;
    logic [SW-1:0]     idx_d;
    logic [SW-1:0]     idx_inc;
    logic [SW-1:0]     score_r;
    logic [SW-1:0]     score_d;
    logic [TW-1:0]     tick;
    logic [TW-1:0]     tick_d;
    logic [NUM_CH-1:0] btn_q;
    logic [NUM_CH-1:0] rise;

    logic [IW-1:0]     seq [MAX_LEN];
    logic              seq_we;
    logic [IW-1:0]     seq_wdata;
    logic [IW-1:0]     seq_cur;
    logic [NUM_CH-1:0] cur_onehot;
    logic [31:0]       rand_ext;

    logic [NUM_CH-1:0] led_d;
    logic              tone_en_d;
    logic [IW-1:0]     tone_sel_d;
    logic [IW-1:0]     btn_low;

    assign rise       = btn & ~btn_q;
    assign idx_inc    = idx + SW'(1);
    assign seq_cur    = seq[idx[AW-1:0]];
    assign cur_onehot = {{(NUM_CH-1){1'b0}}, 1'b1} << seq_cur;
    assign rand_ext   = 32'(rand_idx);
    assign seq_wdata  = IW'(rand_ext % NUM_CH);

    // Sequence memory is deliberately left out of reset; len bounds every read.
    always_ff @(posedge clk) begin
        if (seq_we) begin
            seq[len[AW-1:0]] <= seq_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            len     <= '0;
            idx     <= '0;
            tick    <= '0;
            score_r <= '0;
            btn_q   <= '0;
        end else begin
            state   <= state_d;
            len     <= len_d;
            idx     <= idx_d;
            tick    <= tick_d;
            score_r <= score_d;
            btn_q   <= btn;
        end
    end

    always_comb begin
        state_d = state;
        len_d   = len;
        idx_d   = idx;
        tick_d  = tick;
        score_d = score_r;
        seq_we  = 1'b0;
        case (state)
            S_IDLE, S_LOSE, S_WIN: begin
                if (start) begin
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                len_d   = '0;
                score_d = '0;
                state_d = S_APPEND;
            end
            S_APPEND: begin
                seq_we  = 1'b1;
                len_d   = len + SW'(1);
                idx_d   = '0;
                tick_d  = '0;
                state_d = S_PLAY_ON;
            end
            S_PLAY_ON: begin
                if (tick == TW'(STEP_TICKS - 1)) begin
                    tick_d  = '0;
                    state_d = S_PLAY_GAP;
                end else begin
                    tick_d = tick + TW'(1);
                end
            end
            S_PLAY_GAP: begin
                if (tick == TW'(GAP_TICKS - 1)) begin
                    tick_d = '0;
                    if (idx_inc < len) begin
                        idx_d   = idx_inc;
                        state_d = S_PLAY_ON;
                    end else begin
                        idx_d   = '0;
                        state_d = S_WAIT_IN;
                    end
                end else begin
                    tick_d = tick + TW'(1);
                end
            end
            S_WAIT_IN: begin
                // A press on the timeout cycle is evaluated first, so it wins.
                if (|rise) begin
                    tick_d = '0;
                    if (rise == cur_onehot) begin
                        if (idx_inc == len) begin
                            score_d = len;
                            state_d = (len == SW'(MAX_LEN)) ? S_WIN : S_APPEND;
                        end else begin
                            idx_d = idx_inc;
                        end
                    end else begin
                        state_d = S_LOSE;
                    end
                end else if (tick == TW'(TIMEOUT_TICKS - 1)) begin
                    state_d = S_LOSE;
                end else begin
                    tick_d = tick + TW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        btn_low = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (btn[i]) begin
                btn_low = IW'(i);
            end
        end
    end

    always_comb begin
        led_d      = '0;
        tone_en_d  = 1'b0;
        tone_sel_d = '0;
        case (state)
            S_PLAY_ON: begin
                led_d      = cur_onehot;
                tone_en_d  = 1'b1;
                tone_sel_d = seq_cur;
            end
            S_WAIT_IN: begin
                led_d      = btn;
                tone_en_d  = |btn;
                tone_sel_d = btn_low;
            end
            default: begin
                led_d      = '0;
                tone_en_d  = 1'b0;
                tone_sel_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led            <= '0;
            tone_en        <= 1'b0;
            tone_sel       <= '0;
            score          <= '0;
            awaiting_input <= 1'b0;
            lose           <= 1'b0;
            win            <= 1'b0;
        end else begin
            led            <= led_d;
            tone_en        <= tone_en_d;
            tone_sel       <= tone_sel_d;
            score          <= score_r;
            awaiting_input <= (state == S_WAIT_IN);
            lose           <= (state == S_LOSE);
            win            <= (state == S_WIN);
        end
    end

endmodule
